// File: rtl/mem_to_uart_tx.sv
// Streams a ROW x COLUMN byte matrix out of a memory block as 8N1 UART frames,
// one frame per element in address order, then pulses complete.
module mem_to_uart_tx #(
    parameter int ROW          = 2,
    parameter int COLUMN       = 2,
    parameter int ADDR_W       = 6,
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              read,
    output logic [ADDR_W-1:0] read_address,
    input  logic [7:0]        data,
    output logic              tx_data,
    output logic              busy,
    output logic              complete
);

    localparam int N      = ROW * COLUMN;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(N - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, START_BIT, DATA_BITS, STOP_BIT, DONE
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  index;
    logic [BAUD_W-1:0]  baud;
    logic [2:0]         bit_cnt;
    logic [7:0]         shift;
    logic               baud_done;

    assign baud_done = (baud == BAUD_LAST);

    // Outputs are registered, so each transition writes the values the next state presents.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            index        <= '0;
            baud         <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            tx_data      <= 1'b1;
            read         <= 1'b0;
            read_address <= '0;
            busy         <= 1'b0;
            complete     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_data  <= 1'b1;
                    complete <= 1'b0;
                    index    <= '0;
                    baud     <= '0;
                    bit_cnt  <= '0;
                    if (start) begin
                        state        <= FETCH;
                        read         <= 1'b1;
                        read_address <= '0;
                        busy         <= 1'b1;
                    end else begin
                        read <= 1'b0;
                        busy <= 1'b0;
                    end
                end
                FETCH: begin
                    read  <= 1'b0;
                    state <= LOAD;
                end
                LOAD: begin
                    shift   <= data;
                    tx_data <= 1'b0;
                    baud    <= '0;
                    state   <= START_BIT;
                end
                START_BIT: begin
                    if (baud_done) begin
                        baud    <= '0;
                        bit_cnt <= '0;
                        tx_data <= shift[0];
                        state   <= DATA_BITS;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA_BITS: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_cnt == 3'd7) begin
                            tx_data <= 1'b1;
                            state   <= STOP_BIT;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shift   <= shift >> 1;
                            tx_data <= shift[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP_BIT: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (index == LAST_INDEX) begin
                            complete <= 1'b1;
                            state    <= DONE;
                        end else begin
                            index        <= index + 1'b1;
                            read         <= 1'b1;
                            read_address <= index + 1'b1;
                            state        <= FETCH;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DONE: begin
                    complete <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_to_uart_tx.sv
// Self-checking bench for mem_to_uart_tx: memory model, UART frame monitor
// with an expected-byte scoreboard, and cycle-exact control checks.
module tb_mem_to_uart_tx;

    localparam int CPB = 4;
    localparam int ELEM_CYC = 2 + 10 * CPB;
    localparam int DONE_CYC = 4 * ELEM_CYC + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       read;
    logic [5:0] read_address;
    logic [7:0] data;
    logic       tx_data;
    logic       busy;
    logic       complete;

    logic [7:0] mem [0:63];
    logic [7:0] exp_q [$];

    int n_compared   = 0;
    int n_mismatched = 0;
    int frames_seen  = 0;

    logic       mon_active = 1'b0;
    int         mon_cnt    = 0;
    logic [7:0] mon_byte;
    logic [7:0] mon_exp;

    mem_to_uart_tx #(
        .ROW(2), .COLUMN(2), .ADDR_W(6), .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .read(read),
        .read_address(read_address), .data(data), .tx_data(tx_data),
        .busy(busy), .complete(complete)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (read) data <= mem[read_address];
    end

    // UART receiver: samples mid-bit at negedges, drops any frame cut by reset.
    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx_data === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                mon_byte   = '0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == 2) begin
                n_compared++;
                if (tx_data !== 1'b0) begin
                    n_mismatched++;
                    $display("[TB] FAIL start_bit_mid: got %b want 0", tx_data);
                end
            end else if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt - 6) % 4 == 0) begin
                mon_byte[(mon_cnt - 6) / 4] = tx_data;
            end else if (mon_cnt == 38) begin
                mon_active = 1'b0;
                frames_seen++;
                n_compared++;
                if (tx_data !== 1'b1) begin
                    n_mismatched++;
                    $display("[TB] FAIL stop_bit: got %b want 1", tx_data);
                end
                n_compared++;
                if (exp_q.size() == 0) begin
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_frame: got %h want none", mon_byte);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_byte !== mon_exp) begin
                        n_mismatched++;
                        $display("[TB] FAIL frame_byte: got %h want %h", mon_byte, mon_exp);
                    end
                end
            end
        end
    end

    task automatic load_mem(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
    endtask

    task automatic push_matrix();
        for (int i = 0; i < 4; i++) exp_q.push_back(mem[i]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_compared++;
            if (tx_data !== 1'b1 || busy !== 1'b0 || read !== 1'b0 || complete !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL reset_outputs: got tx=%b busy=%b read=%b complete=%b want 1 0 0 0",
                         tx_data, busy, read, complete);
            end
        end
        start = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_matrix();
        int reads = 0;
        load_mem(8'h01, 8'h02, 8'h03, 8'h04);
        push_matrix();
        start = 1'b1;
        for (int k = 1; k <= DONE_CYC + 3; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            n_compared++;
            if (read !== ((k - 1) % ELEM_CYC == 0 && k < DONE_CYC)) begin
                n_mismatched++;
                $display("[TB] FAIL read_strobe: cycle %0d got %b", k, read);
            end
            if (read === 1'b1) begin
                n_compared++;
                if (read_address !== 6'(reads)) begin
                    n_mismatched++;
                    $display("[TB] FAIL read_address: got %0d want %0d", read_address, reads);
                end
                reads++;
            end
            n_compared++;
            if (busy !== (k <= DONE_CYC) || complete !== (k == DONE_CYC)) begin
                n_mismatched++;
                $display("[TB] FAIL busy_complete: cycle %0d got busy=%b complete=%b", k, busy, complete);
            end
        end
        n_compared++;
        if (reads != 4 || exp_q.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL matrix_totals: got reads=%0d pending=%0d want 4 0", reads, exp_q.size());
        end
    endtask

    task automatic test_bit_timing();
        logic [9:0] exp_bits = 10'b1101001010;
        load_mem(8'hA5, 8'h3C, 8'h80, 8'h7E);
        push_matrix();
        start = 1'b1;
        for (int k = 1; k <= DONE_CYC + 3; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k <= 2 + 10 * CPB) begin
                n_compared++;
                if (k <= 2 && tx_data !== 1'b1) begin
                    n_mismatched++;
                    $display("[TB] FAIL a5_pre_idle: cycle %0d got %b want 1", k, tx_data);
                end else if (k > 2 && tx_data !== exp_bits[(k - 3) / CPB]) begin
                    n_mismatched++;
                    $display("[TB] FAIL a5_bit: cycle %0d got %b want %b", k, tx_data, exp_bits[(k - 3) / CPB]);
                end
            end
        end
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL a5_pending: got %0d want 0", exp_q.size());
        end
    endtask

    task automatic test_busy_ignore();
        int completes = 0;
        int reads = 0;
        int f0 = frames_seen;
        load_mem(8'h00, 8'hFF, 8'h00, 8'hFF);
        push_matrix();
        start = 1'b1;
        for (int k = 1; k <= DONE_CYC + 6; k++) begin
            @(negedge clk);
            if (k == 1 || k == 61) start = 1'b0;
            if (k == 60) start = 1'b1;
            if (complete === 1'b1) completes++;
            if (read === 1'b1) reads++;
        end
        n_compared++;
        if (completes != 1 || reads != 4 || frames_seen - f0 != 4 || exp_q.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL busy_ignore: got completes=%0d reads=%0d frames=%0d want 1 4 4",
                     completes, reads, frames_seen - f0);
        end
    endtask

    task automatic test_back_to_back();
        int completes = 0;
        int idles = 0;
        int reads = 0;
        load_mem(8'h5A, 8'hC3, 8'h0F, 8'hF0);
        push_matrix();
        push_matrix();
        start = 1'b1;
        for (int k = 1; k <= 2 * DONE_CYC + 8; k++) begin
            @(negedge clk);
            if (complete === 1'b1) completes++;
            if (read === 1'b1) reads++;
            if (k <= 2 * DONE_CYC + 1 && busy === 1'b0) idles++;
            if (k == DONE_CYC + 1) begin
                n_compared++;
                if (busy !== 1'b0 || tx_data !== 1'b1 || read !== 1'b0) begin
                    n_mismatched++;
                    $display("[TB] FAIL gap_idle: got busy=%b tx=%b read=%b want 0 1 0", busy, tx_data, read);
                end
            end
            if (k == DONE_CYC + 2) begin
                n_compared++;
                if (read !== 1'b1 || read_address !== 6'd0) begin
                    n_mismatched++;
                    $display("[TB] FAIL restart_fetch: got read=%b addr=%0d want 1 0", read, read_address);
                end
            end
            if (k == 2 * DONE_CYC + 1) start = 1'b0;
        end
        n_compared++;
        if (completes != 2 || idles != 1 || reads != 8 || busy !== 1'b0 || exp_q.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL back_to_back: got completes=%0d idles=%0d reads=%0d busy=%b want 2 1 8 0",
                     completes, idles, reads, busy);
        end
    endtask

    task automatic test_mid_reset();
        int completes = 0;
        int first_addr = -1;
        int f0;
        load_mem(8'h11, 8'h22, 8'h33, 8'h44);
        push_matrix();
        f0 = frames_seen;
        start = 1'b1;
        for (int k = 1; k <= 160; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (complete === 1'b1) completes++;
            if (k == 99) rst = 1'b1;
            if (k == 100) begin
                n_compared++;
                if (tx_data !== 1'b1 || busy !== 1'b0 || read !== 1'b0) begin
                    n_mismatched++;
                    $display("[TB] FAIL abort_outputs: got tx=%b busy=%b read=%b want 1 0 0", tx_data, busy, read);
                end
                exp_q.delete();
            end
            if (k == 101) rst = 1'b0;
        end
        n_compared++;
        if (completes != 0 || frames_seen - f0 != 2 || tx_data !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL abort_quiet: got completes=%0d frames=%0d tx=%b want 0 2 1",
                     completes, frames_seen - f0, tx_data);
        end
        push_matrix();
        f0 = frames_seen;
        start = 1'b1;
        for (int k = 1; k <= DONE_CYC + 3; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (read === 1'b1 && first_addr < 0) first_addr = int'(read_address);
            if (complete === 1'b1) completes++;
        end
        n_compared++;
        if (first_addr != 0 || completes != 1 || frames_seen - f0 != 4 || exp_q.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL resume_fresh: got addr=%0d completes=%0d frames=%0d want 0 1 4",
                     first_addr, completes, frames_seen - f0);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
        test_reset();
        test_matrix();
        test_bit_timing();
        test_busy_ignore();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
